// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH) and a borrow flag
//   that is 1 iff a < b. The datapath is one full-subtractor cell, a borrow flop,
//   operand shift registers, a result shift register and a bit counter. One bit
//   is processed per clock, LSB first.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous, active-low reset
//   in_valid    in   1      operands a/b valid
//   in_ready    out  1      block can accept operands (high only in IDLE)
//   a           in   WIDTH  minuend, unsigned
//   b           in   WIDTH  subtrahend, unsigned
//   out_valid   out  1      diff/borrow_out valid (high only in DONE)
//   out_ready   in   1      consumer accepts result
//   diff        out  WIDTH  a - b modulo 2^WIDTH
//   borrow_out  out  1      final borrow out of the MSB
//   dbg_state   out  2      current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_valid is only sampled in IDLE; diff/borrow_out are held stable while
// out_valid is high and out_ready is low, and out_ready is ignored otherwise.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic             br_out;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             br_next;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs.
    assign d        = sa[0] ^ sb[0] ^ br;
    assign br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last_bit = (cnt == LAST_BIT);

    // Handshake outputs are decoded from the state register only.
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign diff       = res;
    assign borrow_out = br_out;
    assign dbg_state  = state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            br     <= 1'b0;
            br_out <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    // Result bits enter at the MSB, so after WIDTH shifts bit 0
                    // of the difference has reached res[0].
                    res <= {d, res[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    if (last_bit) begin
                        br_out <= br_next;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // DONE: hold results until the consumer takes them; they
                    // also remain on the ports after returning to IDLE.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and random stimulus for serial_subtractor (WIDTH=8). Expected
//   results are pushed to exp_q when operands are driven and popped when the
//   DUT raises out_valid.

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;

    logic [W:0] exp_q[$];

    // Clock / reset
    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .dbg_state  (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one operation and retire it.
    //   gap   idle cycles before presenting operands
    //   hold  cycles out_ready is held low once DONE is reached
    //   noise 0: quiet, 1: in_valid with a=9,b=1 while busy, 2: random in_valid/a/b while busy
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input int gap, input int hold, input int noise);
        logic [W:0]   want;
        logic [W-1:0] dexp;
        int           k;
        in_valid = 1'b0;
        repeat (gap) tick();
        k = 0;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        check("accept_ready", in_ready, 1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        dexp     = op_a - op_b;
        exp_q.push_back({(op_a < op_b), dexp});
        tick();
        in_valid = 1'b0;
        check("busy_in_ready", in_ready, 0);
        k = 0;
        while (!out_valid && k < 200) begin
            if (noise == 1) begin
                in_valid = 1'b1;
                a        = W'(9);
                b        = W'(1);
            end else if (noise == 2) begin
                in_valid = 1'($urandom_range(0, 1));
                a        = W'($urandom);
                b        = W'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        in_valid = 1'b0;
        check("latency", k, W);
        check("out_valid", out_valid, 1);
        want = exp_q.pop_front();
        check("diff", diff, want[W-1:0]);
        check("borrow", borrow_out, want[W]);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = (noise != 0);
            a        = W'($urandom);
            b        = W'($urandom);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_diff", diff, want[W-1:0]);
            check("hold_borrow", borrow_out, want[W]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_hs_valid", out_valid, 0);
        check("post_hs_ready", in_ready, 1);
        check("post_hs_diff", diff, want[W-1:0]);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // Basic and boundary operand pairs
        do_op(8'd5,   8'd3,   0, 0, 0);
        do_op(8'd3,   8'd5,   0, 0, 0);
        do_op(8'd0,   8'd1,   1, 0, 0);
        do_op(8'd0,   8'd0,   0, 0, 0);
        do_op(8'd255, 8'd255, 2, 0, 0);
        do_op(8'd255, 8'd0,   0, 0, 0);

        // Backpressure in DONE with input noise
        do_op(8'd200, 8'd55,  0, 5, 2);

        // Operands a=9,b=1 offered during SHIFT are ignored, then taken in IDLE
        do_op(8'd5,   8'd3,   0, 0, 1);
        do_op(8'd9,   8'd1,   0, 0, 0);

        // Reset in the middle of SHIFT discards the operation
        a        = 8'd200;
        b        = 8'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid_busy", in_ready, 0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_borrow", borrow_out, 0);
        do_op(8'd200, 8'd100, 0, 0, 0);

        // Random operations with gaps, backpressure and input noise
        for (int n = 0; n < 1000; n++) begin
            do_op(W'($urandom), W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 2);
        end

        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
